// File: rtl/riscv_pkg.sv
// Shared definitions for the Riscv151 memory-access stage.
//   - RV32I load/store funct3 encodings (F3_LB .. F3_LHU)
//   - byte-lane write masks for byte, halfword and word stores
//   - helpers that classify a request offset and pick its lane mask
package riscv_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // A halfword may sit at offsets 0..2 because it only has to fit inside
  // one word, not be naturally aligned. Reserved encodings are illegal.
  function automatic logic lsu_illegal(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = (off == 2'd3);
      F3_LW:         bad = (off != 2'd0);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Lane mask at offset 0; only the size bits of funct3 matter.
  function automatic logic [3:0] lsu_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = MASK_B;
      2'b01:   m = MASK_H;
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// load_align_ext: combinational load-data alignment and extension.
// Ports:
//   word   in  32  raw dmem word (or held copy of it)
//   off    in  2   byte offset of the access within the word
//   f3     in  3   RV32I load funct3 selecting size and signedness
//   result out 32  right-justified, sign- or zero-extended load value
module load_align_ext
  import riscv_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        f3,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] sh;

  // Bring the addressed byte to lane 0 so every size extracts from [7:0]/[15:0].
  assign sh = word >> {off, 3'b000};

  always_comb begin
    result = sh;
    case (f3)
      F3_LB:   result = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  result = {24'd0, sh[7:0]};
      F3_LH:   result = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  result = {16'd0, sh[15:0]};
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the 3-stage Riscv151 core.
// Converts byte/half/word loads and stores from execute into word-addressed
// accesses of a synchronous-read dmem with byte write-enables, and one cycle
// later aligns/extends the returned word for writeback.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_store      memory op present / store (1) vs load (0)
//   req_funct3/req_addr      access size+sign, byte address
//   req_wdata/req_rd         store data, load destination register
//   stall                    pipeline freeze (upstream holds req_* stable)
//   dmem_en/we/addr/wdata    dmem request (we is per byte lane)
//   dmem_rdata               dmem read word, valid the cycle after dmem_en
//   wb_valid/wb_rd/wb_data   load result for the register file
//   misalign                 one-cycle pulse after an illegal request
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int DMEM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_store,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [4:0]         req_rd,
  input  logic               stall,
  output logic               dmem_en,
  output logic [3:0]         dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               misalign
);

  logic [1:0] off_p0;
  logic       illegal_p0;
  logic       accept_p0;

  // Upper address bits lie outside dmem and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:DMEM_AW+2];

  // ---- stage 0: issue to dmem ----
  assign off_p0     = req_addr[1:0];
  assign illegal_p0 = lsu_illegal(req_funct3, off_p0);
  assign accept_p0  = req_valid & ~stall;

  assign dmem_en    = accept_p0 & ~illegal_p0;
  assign dmem_addr  = req_addr[DMEM_AW+1:2];
  assign dmem_we    = (dmem_en & req_store) ? (lsu_mask(req_funct3) << off_p0) : 4'b0000;
  assign dmem_wdata = req_wdata << {off_p0, 3'b000};

  // ---- stage 1: load result register and stall hold buffer ----
  logic        vld_p1_d,   vld_p1_q;
  logic        bad_p1_d,   bad_p1_q;
  logic [2:0]  f3_p1_d,    f3_p1_q;
  logic [1:0]  off_p1_d,   off_p1_q;
  logic [4:0]  rd_p1_d,    rd_p1_q;
  logic        hold_vld_d, hold_vld_q;
  logic [31:0] hold_data_d, hold_data_q;
  logic        misalign_d, misalign_q;

  always_comb begin
    vld_p1_d    = vld_p1_q;
    bad_p1_d    = bad_p1_q;
    f3_p1_d     = f3_p1_q;
    off_p1_d    = off_p1_q;
    rd_p1_d     = rd_p1_q;
    hold_vld_d  = 1'b0;
    hold_data_d = hold_data_q;
    // Only pulse when the request is actually taken, so a stalled
    // illegal request does not repeat the pulse.
    misalign_d  = accept_p0 & illegal_p0;

    if (!stall) begin
      vld_p1_d = req_valid & ~req_store;
      bad_p1_d = req_valid & illegal_p0;
      f3_p1_d  = req_funct3;
      off_p1_d = off_p0;
      rd_p1_d  = req_rd;
    end else begin
      // dmem_rdata is only guaranteed in the cycle after the read, so grab
      // it in the first stalled cycle and serve from the copy afterwards.
      hold_vld_d = hold_vld_q | vld_p1_q;
      if (vld_p1_q && !hold_vld_q) begin
        hold_data_d = dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      bad_p1_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      bad_p1_q   <= bad_p1_d;
      hold_vld_q <= hold_vld_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    f3_p1_q     <= f3_p1_d;
    off_p1_q    <= off_p1_d;
    rd_p1_q     <= rd_p1_d;
    hold_data_q <= hold_data_d;
  end

  // ---- stage 2: align, extend and present to writeback ----
  logic [31:0] src_p1;
  logic [31:0] result_p1;

  assign src_p1 = hold_vld_q ? hold_data_q : dmem_rdata;

  load_align_ext u_align (
    .word   (src_p1),
    .off    (off_p1_q),
    .f3     (f3_p1_q),
    .result (result_p1)
  );

  // Data registers carry no reset, so outputs are gated by the valid bit.
  assign wb_valid = vld_p1_q;
  assign wb_rd    = vld_p1_q ? rd_p1_q : 5'd0;
  assign wb_data  = (vld_p1_q && !bad_p1_q) ? result_p1 : 32'd0;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import riscv_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic [4:0]    req_rd;
  logic          stall;
  logic          dmem_en;
  logic [3:0]    dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          misalign;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DMEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  // Synchronous-read BRAM model, read-before-write; garb_en replaces the
  // read port with a changing pattern to prove the DUT holds its own copy.
  logic [31:0] mem [0:15];
  logic [31:0] rdata_q;
  logic [31:0] garb;
  logic        garb_en;

  always @(posedge clk) begin
    garb <= {garb[30:0], garb[31]} ^ 32'h0F0F_0000;
    if (dmem_en) begin
      rdata_q <= mem[dmem_addr[3:0]];
      for (int i = 0; i < 4; i++) begin
        if (dmem_we[i]) mem[dmem_addr[3:0]][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  assign dmem_rdata = garb_en ? garb : rdata_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the result cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] exp, input logic exp_mis);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = f3; req_addr = addr; req_rd = rd;
    #1;
    chk({tag, ".en"}, {31'd0, dmem_en}, {31'd0, ~exp_mis});
    chk({tag, ".we"}, {28'd0, dmem_we}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".vld"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, rd});
    chk({tag, ".data"}, wb_data, exp);
    chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, exp_mis});
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_we,
                          input logic exp_mis);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = 5'd0;
    #1;
    chk({tag, ".we"}, {28'd0, dmem_we}, {28'd0, exp_we});
    chk({tag, ".en"}, {31'd0, dmem_en}, {31'd0, ~exp_mis});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, exp_mis});
    chk({tag, ".wbv"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; stall = 1'b0;
    garb = 32'h1234_5678; garb_en = 1'b0; rdata_q = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    mem[0] <= 32'h8081_7F01;
    mem[3] <= 32'hCAFE_BABE;
    mem[4] <= 32'h0BAD_F00D;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.wbv",  {31'd0, wb_valid}, 32'd0);
    chk("rst.rd",   {27'd0, wb_rd}, 32'd0);
    chk("rst.data", wb_data, 32'd0);
    chk("rst.en",   {31'd0, dmem_en}, 32'd0);
    chk("rst.we",   {28'd0, dmem_we}, 32'd0);
    chk("rst.mis",  {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: byte loads
    do_load("lbu0", F3_LBU, 32'd0, 5'd1, 32'h0000_0001, 1'b0);
    do_load("lbu1", F3_LBU, 32'd1, 5'd2, 32'h0000_007F, 1'b0);
    do_load("lbu2", F3_LBU, 32'd2, 5'd3, 32'h0000_0081, 1'b0);
    do_load("lbu3", F3_LBU, 32'd3, 5'd4, 32'h0000_0080, 1'b0);
    do_load("lb0",  F3_LB,  32'd0, 5'd5, 32'h0000_0001, 1'b0);
    do_load("lb1",  F3_LB,  32'd1, 5'd6, 32'h0000_007F, 1'b0);
    do_load("lb2",  F3_LB,  32'd2, 5'd7, 32'hFFFF_FF81, 1'b0);
    do_load("lb3",  F3_LB,  32'd3, 5'd8, 32'hFFFF_FF80, 1'b0);

    // 2: halfword loads, including the one that crosses the word
    do_load("lh0", F3_LH, 32'd0, 5'd9,  32'h0000_7F01, 1'b0);
    do_load("lh1", F3_LH, 32'd1, 5'd10, 32'hFFFF_817F, 1'b0);
    do_load("lh2", F3_LH, 32'd2, 5'd11, 32'hFFFF_8081, 1'b0);
    do_load("lhu1", F3_LHU, 32'd1, 5'd12, 32'h0000_817F, 1'b0);
    do_load("lh3", F3_LH, 32'd3, 5'd13, 32'h0000_0000, 1'b1);
    @(posedge clk); #1;
    chk("lh3.pulse", {31'd0, misalign}, 32'd0);

    // 3: halfword stores at every offset of word 1
    do_store("sh4", F3_LH, 32'd4, 32'h1122_3344, 4'b0011, 1'b0);
    chk("sh4.mem", mem[1], 32'h0000_3344);
    mem[1] <= 32'd0; #1;
    do_store("sh5", F3_LH, 32'd5, 32'h1122_3344, 4'b0110, 1'b0);
    chk("sh5.mem", mem[1], 32'h0033_4400);
    mem[1] <= 32'd0; #1;
    do_store("sh6", F3_LH, 32'd6, 32'h1122_3344, 4'b1100, 1'b0);
    chk("sh6.mem", mem[1], 32'h3344_0000);
    mem[1] <= 32'd0; #1;
    do_store("sh7", F3_LH, 32'd7, 32'h1122_3344, 4'b0000, 1'b1);
    chk("sh7.mem", mem[1], 32'h0000_0000);
    do_store("sb9", F3_LB, 32'd9, 32'h0000_00A5, 4'b0010, 1'b0);
    chk("sb9.mem", mem[2], 32'h0000_A500);

    // 4: store then load of the same word back to back
    do_store("sw8", F3_LW, 32'd8, 32'h1122_3344, 4'b1111, 1'b0);
    do_load("lw8", F3_LW, 32'd8, 5'd14, 32'h1122_3344, 1'b0);
    do_load("lw9", F3_LW, 32'd9, 5'd15, 32'h0000_0000, 1'b1);
    do_load("rsv", 3'b011, 32'd8, 5'd16, 32'h0000_0000, 1'b1);

    // 5: stall while the load result is pending
    do_load("stl", F3_LW, 32'd12, 5'd17, 32'hCAFE_BABE, 1'b0);
    stall = 1'b1;
    @(posedge clk); #1;
    garb_en = 1'b1;
    chk("stl.c2.vld", {31'd0, wb_valid}, 32'd1);
    chk("stl.c2.data", wb_data, 32'hCAFE_BABE);
    @(posedge clk); #1;
    chk("stl.c3.vld", {31'd0, wb_valid}, 32'd1);
    chk("stl.c3.data", wb_data, 32'hCAFE_BABE);
    chk("stl.c3.rd", {27'd0, wb_rd}, 32'd17);
    @(posedge clk); #1;
    stall = 1'b0;
    #1;
    chk("stl.rel.vld", {31'd0, wb_valid}, 32'd1);
    chk("stl.rel.data", wb_data, 32'hCAFE_BABE);
    @(posedge clk); #1;
    garb_en = 1'b0;
    chk("stl.done.vld", {31'd0, wb_valid}, 32'd0);

    // 6: reset in the cycle after a load issue
    do_load("rl", F3_LW, 32'd16, 5'd7, 32'h0BAD_F00D, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rl.vld",  {31'd0, wb_valid}, 32'd0);
    chk("rl.mis",  {31'd0, misalign}, 32'd0);
    chk("rl.rd",   {27'd0, wb_rd}, 32'd0);
    chk("rl.data", wb_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
